// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the three-requester MCU bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mcu_bus_pkg;

    localparam int NUM_REQ         = 3;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int CNT_W           = 5;

    // Requester IDs, also the grant bit positions
    localparam logic [1:0] REQ_FCU   = 2'd0;
    localparam logic [1:0] REQ_EU    = 2'd1;
    localparam logic [1:0] REQ_STACK = 2'd2;

    // Round-robin pointer after reset: search starts after stack, so fcu wins first
    localparam logic [1:0] RR_RESET_PTR = REQ_STACK;

    // Address map: last address of each region, ext_mem takes everything above GPR
    localparam logic [15:0] ROM_LAST = 16'h3FFF;
    localparam logic [15:0] RAM_LAST = 16'h7FFF;
    localparam logic [15:0] GPR_LAST = 16'h80FF;

    // Target one-hot bit positions, also the chip-select ordering
    localparam int TGT_ROM = 0;
    localparam int TGT_RAM = 1;
    localparam int TGT_GPR = 2;
    localparam int TGT_EXT = 3;
    localparam int NUM_TGT = 4;

    typedef logic [NUM_TGT-1:0] tgt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Next requester ID in round-robin order, wrapping after the last one
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == 2'(NUM_REQ - 1)) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/bus_addr_dec.sv
// Address decoder: maps an address to a one-hot target and flags ROM writes.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module bus_addr_dec
    import mcu_bus_pkg::*;
(
    input  logic [15:0] address,
    input  logic        rd,
    output tgt_t        target,
    output logic        illegal
);

    // Region compare in ascending order; the full 16-bit space is covered
    always_comb begin
        target = '0;
        if (address <= ROM_LAST) begin
            target[TGT_ROM] = 1'b1;
        end else if (address <= RAM_LAST) begin
            target[TGT_RAM] = 1'b1;
        end else if (address <= GPR_LAST) begin
            target[TGT_GPR] = 1'b1;
        end else begin
            target[TGT_EXT] = 1'b1;
        end
        illegal = target[TGT_ROM] & ~rd;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for fcu/eu/stack with address decode, chip selects and timeout.
// Latency: grant/cs one cycle after req sampled; done pulses the cycle after target ready.
// Backpressure: requests are held off while an access is in ACCESS or DONE.
module bus_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int NREQ    = NUM_REQ
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rd,
    input  logic [15:0]     addr0,
    input  logic [15:0]     addr1,
    input  logic [15:0]     addr2,
    input  logic            ready_ram,
    input  logic            ready_rom,
    input  logic            ready_ext_mem,
    input  logic            ready_gpr,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            cs_ram,
    output logic            cs_rom,
    output logic            cs_ext_mem,
    output logic            cs_gpr,
    output logic            read,
    output logic [15:0]     address
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       rr_ptr;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             any_req;
    logic [15:0]      sel_addr;
    logic             sel_rd;
    tgt_t             sel_tgt;
    logic             sel_illegal;
    tgt_t             cs_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             tgt_ready;
    logic             illegal_acc;
    logic             timeout;
    logic             acc_end;

    // Round-robin search starting at the requester after the last one granted
    always_comb begin
        cand    = rr_next(rr_ptr);
        winner  = cand;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
            cand = rr_next(cand);
        end
    end

    // Pick the winning requester's address and direction for decode and latching
    always_comb begin
        sel_addr = addr2;
        sel_rd   = rd[REQ_STACK];
        case (winner)
            REQ_FCU: begin
                sel_addr = addr0;
                sel_rd   = rd[REQ_FCU];
            end
            REQ_EU: begin
                sel_addr = addr1;
                sel_rd   = rd[REQ_EU];
            end
            default: ;
        endcase
    end

    bus_addr_dec u_dec (
        .address (sel_addr),
        .rd      (sel_rd),
        .target  (sel_tgt),
        .illegal (sel_illegal)
    );

    // Only the selected target's ready counts. An illegal access latched no
    // chip select, so an all-zero cs in ACCESS means "finish with error now".
    assign tgt_ready   = |(cs_q & {ready_ext_mem, ready_gpr, ready_ram, ready_rom});
    assign illegal_acc = ~|cs_q;
    assign timeout     = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign acc_end     = tgt_ready | illegal_acc | timeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
            ST_ACCESS: if (acc_end) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output registers, wait counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            cs_q     <= '0;
            read     <= 1'b1;
            address  <= '0;
            wait_cnt <= '0;
            rr_ptr   <= RR_RESET_PTR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant    <= NREQ'(1) << winner;
                        address  <= sel_addr;
                        read     <= sel_rd;
                        cs_q     <= sel_illegal ? '0 : sel_tgt;
                        wait_cnt <= '0;
                        rr_ptr   <= winner;
                    end
                end
                ST_ACCESS: begin
                    if (acc_end) begin
                        grant <= '0;
                        cs_q  <= '0;
                        done  <= grant;
                        // Ready beats a coincident timeout
                        err   <= ~tgt_ready;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= '0;
                    err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cs_rom     = cs_q[TGT_ROM];
    assign cs_ram     = cs_q[TGT_RAM];
    assign cs_gpr     = cs_q[TGT_GPR];
    assign cs_ext_mem = cs_q[TGT_EXT];

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, cycles allowed in ACCESS before abort.
REQ-002 Parameter: NREQ, fixed 3, requester count (0=fcu, 1=eu, 2=stack).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester access request, level.
REQ-006 rd  input  3  per-requester direction; 1=read, 0=write.
REQ-007 addr0, addr1, addr2  input  16 each  per-requester address.
REQ-008 ready_ram, ready_rom, ready_ext_mem, ready_gpr  input  1 each  target completion.
REQ-009 grant  output  3  one-hot owner of bus; all zero when idle.
REQ-010 done  output  3  one-cycle completion pulse to owner.
REQ-011 err  output  1  one-cycle pulse with done on timeout or illegal target.
REQ-012 cs_ram, cs_rom, cs_ext_mem, cs_gpr  output  1 each  target chip selects.
REQ-013 read  output  1  latched direction of current access.
REQ-014 address  output  16  latched address of current access.

Function
REQ-015 States IDLE, ACCESS, DONE; IDLE->ACCESS when any req high; ACCESS->DONE on selected ready or timeout; DONE->IDLE unconditionally.
REQ-016 Arbitration in IDLE is round-robin: search starts at requester after last granted (pointer reset to 2, so requester 0 wins first).
REQ-017 On IDLE->ACCESS edge, grant, address, read and exactly one cs are registered; cs is valid the cycle after req is first sampled.
REQ-018 Decode: 0x0000-0x3FFF ROM, 0x4000-0x7FFF RAM, 0x8000-0x80FF GPR, 0x8100-0xFFFF ext_mem.
REQ-019 Write to ROM is illegal: no cs asserted, go straight to DONE with err=1 and done pulsed.
REQ-020 Only the ready of the selected target is honoured; other readys ignored.
REQ-021 ACCESS->DONE on the edge where selected ready=1; in DONE, done[owner]=1 for one cycle, cs and grant cleared.
REQ-022 Wait counter (5 bits) clears on entering ACCESS, increments each ACCESS cycle; reaching TIMEOUT without ready forces DONE with err=1.
REQ-023 Ready and timeout in same cycle: ready wins, err=0.
REQ-024 Requester dropping req during ACCESS does not abort; access completes and done still pulses.
REQ-025 address/read/grant held stable for whole ACCESS; requester inputs sampled only on grant edge.
REQ-026 Minimum spacing between grants is one DONE cycle; back-to-back requests rotate per REQ-016.
REQ-027 Round-robin pointer updates only on grant, not on done.

Reset
REQ-028 On reset: state=IDLE, grant=0, done=0, err=0, all cs=0, read=1, address=0x0000, counter=0, pointer=2.
REQ-029 Reset mid-ACCESS aborts without done pulse; all outputs reach reset values at that edge.

Structure
REQ-030 Shared package mcu_bus_pkg holds state encoding, requester IDs, address-map bounds, default TIMEOUT.
REQ-031 Address decode is a separate combinational sub-module bus_addr_dec (address, rd -> target one-hot, illegal).
REQ-032 Arbiter FSM, counter and output registers live in bus_arbiter; est. 150-250 RTL lines total.

Verification
REQ-033 req=3'b001 rd=1 addr0=0x0010, ready_rom after 2 cycles -> grant=001, cs_rom=1, done[0] pulse, err=0.
REQ-034 req=3'b111 held, ready immediate each access -> grants 001,010,100,001 in order, one DONE gap each.
REQ-035 req[1] rd=0 addr1=0x0100 (ROM write) -> no cs, done[1] and err pulse 2 cycles after req.
REQ-036 req[2] addr2=0x9000, no ready -> cs_ext_mem high 16 cycles, then done[2]+err, cs cleared.
REQ-037 ready_ram and counter=TIMEOUT same cycle on addr 0x4000 -> done pulse, err=0.
REQ-038 reset asserted during ACCESS to 0x8005 -> next edge cs_gpr=0, grant=0, no done, pointer=2.
